// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO. Frames are sent back-to-back while
// words are buffered: start bit, DATA_BITS data bits LSB first, optional
// parity bit, then STOP_BITS stop bits.
module uart_tx_fifo #(
  parameter int unsigned CLK_PER_BIT = 2604,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [DATA_BITS-1:0]          i_data,
  input  logic                          i_tx_send,
  output logic                          o_tx_ready,
  output logic                          o_tx,
  output logic                          o_tx_hs,
  output logic                          o_active,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int unsigned CW = $clog2(CLK_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CLK_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CLK_PRE   = CW'(CLK_PER_BIT - 2);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [PW:0]   CNT_FULL  = (PW + 1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ONE   = (PW + 1)'(1);
  // Mode 3 (and anything else) falls back to no parity.
  localparam bit PAR_EN  = (PARITY_MODE == 1) || (PARITY_MODE == 2);
  localparam bit PAR_ODD = (PARITY_MODE == 2);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // FIFO storage and pointers
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [PW:0]          r_count;

  // Transmit state
  state_e               r_state, w_state_next;
  logic [CW-1:0]        r_clk_cnt, w_clk_cnt_next;
  logic [BW-1:0]        r_bit_cnt, w_bit_cnt_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic                 r_par, w_par_next;
  logic                 r_tx, w_tx_next;
  logic                 r_active, w_active_next;
  logic                 r_tx_hs, w_tx_hs_next;

  logic                 w_push, w_pop;
  logic [DATA_BITS-1:0] w_head;

  assign o_tx_ready   = (r_count != CNT_FULL);
  assign o_fifo_count = r_count;
  assign o_tx         = r_tx;
  assign o_active     = r_active;
  assign o_tx_hs      = r_tx_hs;

  assign w_push = i_tx_send && o_tx_ready;
  assign w_head = r_mem[r_rd_ptr];

  // FIFO storage write; contents need no reset since pointers define validity
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame sequencer next state; line outputs are derived from the next state so they register
  always_comb begin
    w_state_next   = r_state;
    w_clk_cnt_next = r_clk_cnt;
    w_bit_cnt_next = r_bit_cnt;
    w_shift_next   = r_shift;
    w_par_next     = r_par;
    w_tx_hs_next   = 1'b0;
    w_pop          = 1'b0;

    case (r_state)
      StIdle: begin
        if (r_count != '0) begin
          w_pop          = 1'b1;
          w_shift_next   = w_head;
          w_par_next     = PAR_ODD ^ (^w_head);
          w_clk_cnt_next = '0;
          w_bit_cnt_next = '0;
          w_state_next   = StStart;
        end
      end
      StStart: begin
        if (r_clk_cnt == CLK_LAST) begin
          w_clk_cnt_next = '0;
          w_bit_cnt_next = '0;
          w_state_next   = StData;
        end else begin
          w_clk_cnt_next = r_clk_cnt + 1'b1;
        end
      end
      StData: begin
        if (r_clk_cnt == CLK_LAST) begin
          w_clk_cnt_next = '0;
          w_shift_next   = r_shift >> 1;
          if (r_bit_cnt == DATA_LAST) begin
            w_bit_cnt_next = '0;
            w_state_next   = PAR_EN ? StParity : StStop;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end else begin
          w_clk_cnt_next = r_clk_cnt + 1'b1;
        end
      end
      StParity: begin
        if (r_clk_cnt == CLK_LAST) begin
          w_clk_cnt_next = '0;
          w_bit_cnt_next = '0;
          w_state_next   = StStop;
        end else begin
          w_clk_cnt_next = r_clk_cnt + 1'b1;
        end
      end
      StStop: begin
        // Registered pulse lands on the final stop cycle.
        if ((r_bit_cnt == STOP_LAST) && (r_clk_cnt == CLK_PRE)) begin
          w_tx_hs_next = 1'b1;
        end
        if (r_clk_cnt == CLK_LAST) begin
          w_clk_cnt_next = '0;
          if (r_bit_cnt == STOP_LAST) begin
            w_bit_cnt_next = '0;
            if (r_count != '0) begin
              w_pop        = 1'b1;
              w_shift_next = w_head;
              w_par_next   = PAR_ODD ^ (^w_head);
              w_state_next = StStart;
            end else begin
              w_state_next = StIdle;
            end
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end else begin
          w_clk_cnt_next = r_clk_cnt + 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase

    case (w_state_next)
      StStart:  w_tx_next = 1'b0;
      StData:   w_tx_next = w_shift_next[0];
      StParity: w_tx_next = w_par_next;
      default:  w_tx_next = 1'b1;
    endcase
    w_active_next = (w_state_next != StIdle);
  end

  // Sequencer state and registered line outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
      r_active  <= 1'b0;
      r_tx_hs   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_clk_cnt <= w_clk_cnt_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_shift   <= w_shift_next;
      r_par     <= w_par_next;
      r_tx      <= w_tx_next;
      r_active  <= w_active_next;
      r_tx_hs   <= w_tx_hs_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three differently configured instances share one
// stimulus stream and are compared every cycle against a frame-level model.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic       send;
  logic [7:0] data;
  logic [2:0] tx, hs, act, rdy;
  logic [2:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic       chk_en;

  int n_cmp;
  int n_fail;

  // Instance 0: 8N1, 4 clk/bit, depth 4
  uart_tx_fifo #(
    .CLK_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_tx_send(send), .o_tx_ready(rdy[0]),
    .o_tx(tx[0]), .o_tx_hs(hs[0]), .o_active(act[0]), .o_fifo_count(cnt_a)
  );

  // Instance 1: 8E2, 4 clk/bit, depth 4
  uart_tx_fifo #(
    .CLK_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_tx_send(send), .o_tx_ready(rdy[1]),
    .o_tx(tx[1]), .o_tx_hs(hs[1]), .o_active(act[1]), .o_fifo_count(cnt_b)
  );

  // Instance 2: 6O1, 3 clk/bit, depth 2
  uart_tx_fifo #(
    .CLK_PER_BIT(3), .DATA_BITS(6), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(2)
  ) u_dut_c (
    .i_clk(clk), .i_rst(rst), .i_data(data[5:0]), .i_tx_send(send), .o_tx_ready(rdy[2]),
    .o_tx(tx[2]), .o_tx_hs(hs[2]), .o_active(act[2]), .o_fifo_count(cnt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cpb_of(input int k);
    return (k == 2) ? 3 : 4;
  endfunction
  function automatic int db_of(input int k);
    return (k == 2) ? 6 : 8;
  endfunction
  function automatic int pm_of(input int k);
    return (k == 0) ? 0 : k;
  endfunction
  function automatic int sb_of(input int k);
    return (k == 1) ? 2 : 1;
  endfunction
  function automatic int dp_of(input int k);
    return (k == 2) ? 2 : 4;
  endfunction
  function automatic logic [31:0] cnt_of(input int k);
    if (k == 0) return 32'(cnt_a);
    if (k == 1) return 32'(cnt_b);
    return 32'(cnt_c);
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, k, $time, got, exp);
    end
  endtask

  // Frame-level model: a word queue per instance plus the line image of the frame in flight
  int m_cnt  [3];
  int m_head [3];
  int m_fifo [3][8];
  bit m_act  [3];
  int m_el   [3];
  int m_len  [3];
  bit m_fb   [3][16];

  task automatic load_frame(input int k, input int w);
    int n;
    int p;
    m_fb[k][0] = 1'b0;
    for (int i = 0; i < db_of(k); i++) m_fb[k][1 + i] = w[i];
    p = $countones(w) % 2;
    n = 1 + db_of(k);
    if (pm_of(k) == 1) begin m_fb[k][n] = (p == 1); n++; end
    if (pm_of(k) == 2) begin m_fb[k][n] = (p == 0); n++; end
    for (int s = 0; s < sb_of(k); s++) begin m_fb[k][n] = 1'b1; n++; end
    m_len[k] = n * cpb_of(k);
    m_el[k]  = 0;
    m_act[k] = 1'b1;
  endtask

  // Advance the model on each rising edge using the same inputs the DUTs sample
  always @(posedge clk) begin : model
    bit push;
    int w;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_cnt[k] = 0; m_head[k] = 0; m_act[k] = 1'b0; m_el[k] = 0;
      end else begin
        push = send && (m_cnt[k] != dp_of(k));
        if (m_act[k]) begin
          m_el[k]++;
          if (m_el[k] == m_len[k]) m_act[k] = 1'b0;
        end
        if (!m_act[k] && m_cnt[k] != 0) begin
          w = m_fifo[k][m_head[k]];
          m_head[k] = (m_head[k] + 1) % dp_of(k);
          m_cnt[k]--;
          load_frame(k, w);
        end
        if (push) begin
          m_fifo[k][(m_head[k] + m_cnt[k]) % dp_of(k)] = int'(data) & ((1 << db_of(k)) - 1);
          m_cnt[k]++;
        end
      end
    end
  end

  // Compare every output of every instance on the falling edge
  always @(negedge clk) begin : compare
    logic etx;
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        etx = m_act[k] ? m_fb[k][m_el[k] / cpb_of(k)] : 1'b1;
        check("o_tx", k, 32'(tx[k]), 32'(etx));
        check("o_active", k, 32'(act[k]), 32'(m_act[k]));
        check("o_tx_hs", k, 32'(hs[k]), 32'(m_act[k] && (m_el[k] == m_len[k] - 1)));
        check("o_fifo_count", k, cnt_of(k), 32'(m_cnt[k]));
        check("o_tx_ready", k, 32'(rdy[k]), 32'(m_cnt[k] != dp_of(k)));
      end
    end
  end

  initial begin : stim
    int          acnt [3];
    int          hcnt [3];
    logic [15:0] cap  [3];
    int          rate;

    n_cmp = 0; n_fail = 0;
    rst = 1'b1; send = 1'b0; data = 8'h00; chk_en = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("reset_tx", k, 32'(tx[k]), 32'd1);
      check("reset_active", k, 32'(act[k]), 32'd0);
      check("reset_hs", k, 32'(hs[k]), 32'd0);
      check("reset_ready", k, 32'(rdy[k]), 32'd1);
      check("reset_count", k, cnt_of(k), 32'd0);
    end
    rst = 1'b0;

    // Single 0xAB: capture one sample per bit period and pin the line image
    data = 8'hAB; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    for (int k = 0; k < 3; k++) begin acnt[k] = 0; hcnt[k] = 0; cap[k] = '0; end
    repeat (60) begin
      for (int k = 0; k < 3; k++) begin
        if (act[k]) begin
          if (acnt[k] % cpb_of(k) == 0) cap[k][acnt[k] / cpb_of(k)] = tx[k];
          acnt[k]++;
        end
        if (hs[k]) hcnt[k]++;
      end
      @(negedge clk);
    end
    check("frame_bits_8n1", 0, 32'(cap[0]), 32'h356);
    check("frame_bits_8e2", 1, 32'(cap[1]), 32'hF56);
    check("frame_bits_6o1", 2, 32'(cap[2]), 32'h1D6);
    check("frame_len_8n1", 0, 32'(acnt[0]), 32'd40);
    check("frame_len_8e2", 1, 32'(acnt[1]), 32'd48);
    check("frame_len_6o1", 2, 32'(acnt[2]), 32'd27);
    for (int k = 0; k < 3; k++) check("hs_pulses_single", k, 32'(hcnt[k]), 32'd1);

    // Six-cycle burst 0x01..0x06 while idle: first pops, FIFO fills, surplus dropped
    for (int i = 1; i <= 6; i++) begin
      data = 8'(i); send = 1'b1;
      @(negedge clk);
    end
    send = 1'b0;
    check("burst_count", 0, cnt_of(0), 32'd4);
    check("burst_ready", 0, 32'(rdy[0]), 32'd0);
    check("burst_count", 1, cnt_of(1), 32'd4);
    check("burst_count", 2, cnt_of(2), 32'd2);
    check("burst_ready", 2, 32'(rdy[2]), 32'd0);
    for (int k = 0; k < 3; k++) hcnt[k] = 0;
    repeat (400) begin
      for (int k = 0; k < 3; k++) if (hs[k]) hcnt[k]++;
      @(negedge clk);
    end
    check("burst_frames", 0, 32'(hcnt[0]), 32'd5);
    check("burst_frames", 1, 32'(hcnt[1]), 32'd5);
    check("burst_frames", 2, 32'(hcnt[2]), 32'd3);

    // Reset during cycle 15 of a frame with two words buffered
    for (int i = 1; i <= 3; i++) begin
      data = 8'(8'h11 * i); send = 1'b1;
      @(negedge clk);
    end
    send = 1'b0;
    repeat (13) @(negedge clk);
    check("pre_reset_count", 0, cnt_of(0), 32'd2);
    check("pre_reset_active", 0, 32'(act[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_tx", 0, 32'(tx[0]), 32'd1);
    check("abort_active", 0, 32'(act[0]), 32'd0);
    check("abort_count", 0, cnt_of(0), 32'd0);
    check("abort_ready", 0, 32'(rdy[0]), 32'd1);
    check("abort_hs", 0, 32'(hs[0]), 32'd0);
    repeat (2) @(negedge clk);

    // Randomised traffic in blocks of varying send density with rare resets
    for (int blk = 0; blk < 12; blk++) begin
      case ($urandom_range(2))
        0:       rate = 3;
        1:       rate = 15;
        default: rate = 60;
      endcase
      for (int c = 0; c < 200; c++) begin
        send = ($urandom_range(99) < rate);
        data = 8'($urandom);
        rst  = ($urandom_range(499) == 0);
        @(negedge clk);
      end
    end
    send = 1'b0; rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
